multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle opcode decoder. A state machine sequences each RISC-V instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and waits on a memory ready handshake, with a timeout. It traps on illegal opcodes and counts retired instructions. It sits between the instruction register and the shared-memory multi-cycle datapath, and drives the same control strobes the datapath already uses.

Parameters:
OPCODE_W, 7, width of opcode field
CNT_W, 32, width of retired-instruction counter
MEM_TIMEOUT, 16, max wait cycles for mem_ready in FETCH/MEM; 0 disables timeout
TRAP_ON_ILLEGAL, 1, 1: unknown opcode traps; 0: unknown opcode retires as NOP

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  instruction register opcode field, valid from DECODE onward
mem_ready  in  1  memory completes current read/write this cycle
pc_write  out  1  PC update strobe, retirement cycle only
ir_write  out  1  instruction register load strobe
alu_src  out  1  0: rs2, 1: immediate
mem_to_reg  out  1  writeback source is memory
reg_write  out  1  register file write enable
mem_read  out  1  memory read request
mem_write  out  1  memory write request
alu_op  out  2  00 LW/SW, 01 branch, 10 R/I, 11 JALR
branch  out  1  BEQ retiring
jal  out  1  JAL retiring
jalr  out  1  JALR retiring
halted  out  1  sticky, HALT executed
trapped  out  1  sticky, trap taken
trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALTED=5, TRAP=6
instret  out  CNT_W  retired instruction count

Behaviour:
- Opcodes: R=0110011, I=0010011, LW=0000011, SW=0100011, BR=1100011, JAL=1101111, JALR=1100111, HALT=1111111.
- Reset (sync): state=FETCH, op_q=0, wait_cnt=0, instret=0, halted=0, trapped=0, trap_cause=00. All strobes are 0 while reset is high. Reset from any state, including HALTED/TRAP or mid-handshake, aborts the current operation. The first post-reset cycle is FETCH with mem_read=1.
- FETCH:
  - mem_read=1 until mem_ready.
  - On mem_ready: ir_write=1 in the same cycle; next state DECODE.
- DECODE: latch opcode into op_q. Next state:
  - R/I/LW/SW/BR/JAL/JALR: EXECUTE.
  - HALT: HALTED.
  - Unknown opcode: TRAP (cause 01) if TRAP_ON_ILLEGAL; otherwise retire as NOP, then FETCH.
- EXECUTE:
  - alu_src=1 for LW/SW/I/JALR.
  - alu_op from op_q per the table above.
  - Next state: LW/SW to MEM; R/I/JAL/JALR to WRITEBACK; BR retires (branch=1), then FETCH.
- MEM:
  - LW holds mem_read=1; SW holds mem_write=1, until mem_ready.
  - On mem_ready: LW goes to WRITEBACK; SW retires, then FETCH.
- WRITEBACK: reg_write=1; mem_to_reg=1 for LW; jal/jalr=1 for JAL/JALR; retire, then FETCH.
- alu_src/alu_op stay valid from op_q in EXECUTE, MEM and WRITEBACK. All strobes are 0 in HALTED and TRAP.
- Retirement cycle:
  - pc_write=1 for exactly one cycle.
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH.
- Minimum latencies (zero-wait memory):
  - BR 3 cycles, NOP 2 cycles.
  - R/I/JAL/JALR 4 cycles, SW 4 cycles, LW 5 cycles.
- Timeout:
  - wait_cnt increments each cycle in FETCH/MEM with mem_ready=0, and clears on any state change.
  - If MEM_TIMEOUT!=0 and wait_cnt reaches MEM_TIMEOUT-1 with mem_ready still 0, next state is TRAP, cause 10.
  - mem_ready in that same cycle wins and no trap occurs.
- HALTED and TRAP are absorbing until reset. halted and trapped are mutually exclusive.
- HALT and illegal opcodes do not increment instret.
- opcode is ignored outside DECODE.

Test Plan:
- ADDI (0010011), mem_ready tied 1 -> states 0,1,2,4,0; reg_write=1 in WB only; alu_src=1, alu_op=10; pc_write single pulse; instret 0 -> 1.
- LW with mem_ready low 3 cycles in MEM, MEM_TIMEOUT=16 -> mem_read held 4 MEM cycles; then WB with mem_to_reg=1, reg_write=1; no trap.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=4 -> after 4 FETCH cycles state=6, trapped=1, trap_cause=10; all strobes 0; instret unchanged.
- Opcode 0000000, TRAP_ON_ILLEGAL=1 -> TRAP, cause 01. Same opcode with TRAP_ON_ILLEGAL=0 -> retires in 2 cycles, instret +1, no reg_write.
- BEQ, then HALT -> branch=1 and pc_write=1 in the EXECUTE cycle; then state=5, halted=1 sticky for 20 cycles; reset -> FETCH, instret=0, halted=0.
- CNT_W=4, retire 17 ADDs -> instret wraps 15 -> 0 -> 1. Reset asserted mid-MEM of SW -> mem_write drops the same cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with memory handshake, timeout trap, illegal-opcode trap, retire counter.
module multicycle_controller #(
   parameter int OPCODE_W        = 7,
   parameter int CNT_W           = 32,
   parameter int MEM_TIMEOUT     = 16,
   parameter int TRAP_ON_ILLEGAL = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic                alu_src,
   output logic                mem_to_reg,
   output logic                reg_write,
   output logic                mem_read,
   output logic                mem_write,
   output logic [1:0]          alu_op,
   output logic                branch,
   output logic                jal,
   output logic                jalr,
   output logic                halted,
   output logic                trapped,
   output logic [1:0]          trap_cause,
   output logic [2:0]          state,
   output logic [CNT_W-1:0]    instret
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALTED    = 3'd5,
      S_TRAP      = 3'd6
   } state_e;

   localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
   localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
   localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(7'b0000011);
   localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(7'b0100011);
   localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
   localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);
   localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
   localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(7'b1111111);

   // Wait counter only ever needs to reach MEM_TIMEOUT-1.
   localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   state_e              state_q, state_d;
   logic [OPCODE_W-1:0] op_q, op_d;
   logic [WC_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]    instret_q, instret_d;
   logic                halted_q, halted_d;
   logic                trapped_q, trapped_d;
   logic [1:0]          trap_cause_q, trap_cause_d;

   logic retire;
   logic timeout_hit;
   logic op_r, op_i, op_lw, op_sw, op_br, op_jal, op_jalr;
   logic in_known;

   assign op_r    = (op_q == OP_R);
   assign op_i    = (op_q == OP_I);
   assign op_lw   = (op_q == OP_LW);
   assign op_sw   = (op_q == OP_SW);
   assign op_br   = (op_q == OP_BR);
   assign op_jal  = (op_q == OP_JAL);
   assign op_jalr = (op_q == OP_JALR);

   assign in_known = (opcode == OP_R)  || (opcode == OP_I)   ||
                     (opcode == OP_LW) || (opcode == OP_SW)  ||
                     (opcode == OP_BR) || (opcode == OP_JAL) ||
                     (opcode == OP_JALR);

   // mem_ready in the final allowed wait cycle still wins over the trap.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                        (wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));

   assign state      = state_q;
   assign instret    = instret_q;
   assign halted     = halted_q;
   assign trapped    = trapped_q;
   assign trap_cause = trap_cause_q;

   // State register and sticky status, synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_FETCH;
         op_q         <= '0;
         wait_cnt_q   <= '0;
         instret_q    <= '0;
         halted_q     <= 1'b0;
         trapped_q    <= 1'b0;
         trap_cause_q <= 2'b00;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         wait_cnt_q   <= wait_cnt_d;
         instret_q    <= instret_d;
         halted_q     <= halted_d;
         trapped_q    <= trapped_d;
         trap_cause_q <= trap_cause_d;
      end
   end

   // Next-state, strobes and bookkeeping.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      wait_cnt_d   = wait_cnt_q;
      instret_d    = instret_q;
      halted_d     = halted_q;
      trapped_d    = trapped_q;
      trap_cause_d = trap_cause_q;
      retire       = 1'b0;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      alu_src      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      alu_op       = 2'b00;
      branch       = 1'b0;
      jal          = 1'b0;
      jalr         = 1'b0;

      if (state_q == S_EXECUTE || state_q == S_MEM ||
          state_q == S_WRITEBACK) begin
         alu_src = op_lw | op_sw | op_i | op_jalr;
         unique case (1'b1)
            op_br:        alu_op = 2'b01;
            op_r | op_i:  alu_op = 2'b10;
            op_jalr:      alu_op = 2'b11;
            default:      alu_op = 2'b00;
         endcase
      end

      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout_hit) begin
               state_d      = S_TRAP;
               trapped_d    = 1'b1;
               trap_cause_d = 2'b10;
            end
         end
         S_DECODE: begin
            op_d = opcode;
            if (in_known) begin
               state_d = S_EXECUTE;
            end else if (opcode == OP_HALT) begin
               state_d  = S_HALTED;
               halted_d = 1'b1;
            end else if (TRAP_ON_ILLEGAL != 0) begin
               state_d      = S_TRAP;
               trapped_d    = 1'b1;
               trap_cause_d = 2'b01;
            end else begin
               retire = 1'b1;
            end
         end
         S_EXECUTE: begin
            if (op_lw || op_sw) begin
               state_d = S_MEM;
            end else if (op_br) begin
               branch = 1'b1;
               retire = 1'b1;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEM: begin
            mem_read  = op_lw;
            mem_write = ~op_lw;
            if (mem_ready) begin
               if (op_lw) state_d = S_WRITEBACK;
               else       retire  = 1'b1;
            end else if (timeout_hit) begin
               state_d      = S_TRAP;
               trapped_d    = 1'b1;
               trap_cause_d = 2'b10;
            end
         end
         S_WRITEBACK: begin
            reg_write  = 1'b1;
            mem_to_reg = op_lw;
            jal        = op_jal;
            jalr       = op_jalr;
            retire     = 1'b1;
         end
         S_HALTED, S_TRAP: begin
            state_d = state_q;
         end
         default: state_d = S_FETCH;
      endcase

      if (retire) begin
         pc_write  = 1'b1;
         instret_d = instret_q + 1'b1;
         state_d   = S_FETCH;
      end

      if (state_d != state_q) begin
         wait_cnt_d = '0;
      end else if ((state_q == S_FETCH || state_q == S_MEM) &&
                   !mem_ready) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end

      // Reset aborts any in-flight request immediately.
      if (reset) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         alu_src    = 1'b0;
         mem_to_reg = 1'b0;
         reg_write  = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         alu_op     = 2'b00;
         branch     = 1'b0;
         jal        = 1'b0;
         jalr       = 1'b0;
      end
   end

endmodule
